// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add unsigned multiplier, one multiplier bit per cycle.
// Borrows an external ripple-carry adder; valid/ready on both sides.
module shift_add_multiplier #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] add_in1,
   output logic [WIDTH-1:0] add_in2,
   output logic             add_ci,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_co
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             accept;
   logic             last;

   assign last    = (count == CW'(WIDTH - 1));
   assign add_ci  = 1'b0;
   assign prod_hi = hi;
   assign prod_lo = lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Adder operands are forced to zero outside BUSY so it stays quiet.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      add_in1   = '0;
      add_in2   = '0;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = rst_n;
            accept   = in_valid;
            if (in_valid) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            add_in1 = hi;
            add_in2 = lo[0] ? mcand : '0;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // {co, sum, lo} shifted right one place: carry lands in hi's MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         mcand <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (accept) begin
         count <= '0;
         mcand <= in_a;
         hi    <= '0;
         lo    <= in_b;
      end else if (state == BUSY) begin
         hi    <= {add_co, add_sum[WIDTH-1:1]};
         lo    <= {add_sum[0], lo[WIDTH-1:1]};
         count <= count + CW'(1);
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed table,
// corner sequences and randomized pairs against a 128-bit reference.
module tb_shift_add_multiplier;
   localparam int W = 64;
   localparam logic [W-1:0] ONES = {W{1'b1}};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] prod_hi;
   logic [W-1:0] prod_lo;
   logic [W-1:0] add_in1;
   logic [W-1:0] add_in2;
   logic         add_ci;
   logic [W-1:0] add_sum;
   logic         add_co;

   always #5 clk = ~clk;

   assign {add_co, add_sum} = {1'b0, add_in1} + {1'b0, add_in2}
                            + {{W{1'b0}}, add_ci};

   shift_add_multiplier #(.WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_a(in_a),
      .in_b(in_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .prod_hi(prod_hi),
      .prod_lo(prod_lo),
      .add_in1(add_in1),
      .add_in2(add_in2),
      .add_ci(add_ci),
      .add_sum(add_sum),
      .add_co(add_co)
   );

   int checks = 0;
   int failures = 0;
   int acc_cnt = 0;
   int hs_cnt = 0;

   always @(posedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) acc_cnt++;
         if (out_valid && out_ready) hs_cnt++;
      end
   end

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      int w = 0;
      while (!in_ready && w < 200) begin
         tick();
         w++;
      end
      if (!in_ready) chk("start_timeout", 0, 1);
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat, output bit rdy_seen);
      lat = 0;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) rdy_seen = 1'b1;
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat;
      bit seen;
      bit bad;
      logic [127:0] snap;
      logic [127:0] exp_q[$];
      logic [127:0] exp;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int acc0;
      int hs0;
      int stall;

      vecs[0] = '{64'd3, 64'd5, 64'd0, 64'd15};
      vecs[1] = '{ONES, ONES, {ONES[W-1:1], 1'b0}, 64'd1};
      vecs[2] = '{64'h8000_0000_0000_0000, 64'd2, 64'd1, 64'd0};
      vecs[3] = '{64'd0, 64'h1234, 64'd0, 64'd0};
      vecs[4] = '{64'h1234, 64'd0, 64'd0, 64'd0};
      vecs[5] = '{64'd7, 64'd9, 64'd0, 64'd63};
      vecs[6] = '{ONES, 64'd1, 64'd0, ONES};

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_a = '0;
      in_b = '0;
      repeat (3) tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_prod", {prod_hi, prod_lo}, 0);
      chk("rst_adder_in", {add_in1, add_in2}, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_in_ready", in_ready, 1);

      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         start_op(vecs[i].a, vecs[i].b);
         wait_done(lat, seen);
         chk($sformatf("vec%0d_prod", i), {prod_hi, prod_lo},
             {vecs[i].hi, vecs[i].lo});
         chk($sformatf("vec%0d_latency", i), lat, W);
         chk($sformatf("vec%0d_busy_ready", i), seen, 0);
         tick();
         chk($sformatf("vec%0d_pulse", i), {out_valid, in_ready}, 2'b01);
      end

      out_ready = 1'b0;
      start_op(64'd11, 64'd13);
      wait_done(lat, seen);
      snap = {prod_hi, prod_lo};
      chk("bp_prod", snap, 143);
      in_valid = 1'b1;
      in_a = 64'd5;
      in_b = 64'd6;
      bad = 1'b0;
      repeat (10) begin
         tick();
         if ({prod_hi, prod_lo} !== snap || !out_valid || in_ready
             || add_in1 != 0 || add_in2 != 0) bad = 1'b1;
      end
      chk("bp_hold", bad, 0);
      out_ready = 1'b1;
      tick();
      chk("bp_release", {out_valid, in_ready}, 2'b01);
      tick();
      in_valid = 1'b0;
      chk("bp_accepted", in_ready, 0);
      wait_done(lat, seen);
      chk("bp_new_latency", lat, W);
      chk("bp_new_prod", {prod_hi, prod_lo}, 30);
      tick();

      start_op(ONES, ONES);
      repeat (30) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out", {out_valid, in_ready}, 0);
      chk("midrst_prod", {prod_hi, prod_lo}, 0);
      chk("midrst_adder", {add_in1, add_in2}, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("midrst_idle", in_ready, 1);
      start_op(64'd7, 64'd9);
      wait_done(lat, seen);
      chk("midrst_7x9", {prod_hi, prod_lo}, 63);
      tick();

      out_ready = 1'b0;
      start_op(64'd3, 64'd3);
      wait_done(lat, seen);
      chk("done_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("donerst_out", {out_valid, prod_hi, prod_lo}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      acc0 = acc_cnt;
      hs0 = hs_cnt;
      for (int i = 0; i < 300; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (i % 16 == 1) ra = ONES;
         if (i % 16 == 2) rb = '0;
         if (i % 16 == 3) rb = ONES;
         exp_q.push_back(128'(ra) * 128'(rb));
         out_ready = 1'($urandom_range(0, 1));
         start_op(ra, rb);
         lat = 0;
         while (!out_valid && lat < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = {$urandom, $urandom};
            in_b = {$urandom, $urandom};
            tick();
            lat++;
         end
         if (!out_valid) chk("rnd_timeout", out_valid, 1);
         exp = exp_q.pop_front();
         chk($sformatf("rnd%0d_prod", i), {prod_hi, prod_lo}, exp);
         out_ready = 1'b0;
         stall = $urandom_range(0, 3);
         bad = 1'b0;
         repeat (stall) begin
            tick();
            if ({prod_hi, prod_lo} !== exp || !out_valid) bad = 1'b1;
         end
         if (bad) chk("rnd_stall_hold", bad, 0);
         in_valid = 1'b0;
         out_ready = 1'b1;
         tick();
      end
      chk("rnd_accepts", acc_cnt - acc0, 300);
      chk("rnd_handshakes", hs_cnt - hs0, 300);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
